// File: rtl/crossbar_pkg.sv
// Shared crossbar constants: default sizing, FSM state encodings and a
// width helper used by every crossbar block.
package crossbar_pkg;

  // Default sizing for a crossbar readout column sweep.
  localparam int CB_N_COLS_DEF        = 8;
  localparam int CB_RES_BITS_DEF      = 8;
  localparam int CB_SETTLE_CYCLES_DEF = 2;

  // Settle counter is sized for the largest legal settle time (15).
  localparam int CB_SETTLE_MAX = 15;
  localparam int CB_CNT_W      = 4;

  // Readout FSM state encodings, also visible on the fsm_state debug port.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_OUTPUT  = 2'd3;

  // Index width that never collapses to zero bits for a count of 1.
  function automatic int cb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crossbar_sar_bit.sv
// Successive-approximation register for one column conversion. Holds the
// current DAC trial code and the bit under test; the parent FSM tells it
// when to start (load), when a trial ends (step) and when to forget (clear).
module crossbar_sar_bit
  import crossbar_pkg::*;
#(
  parameter int  RES_BITS = CB_RES_BITS_DEF,
  localparam int IDX_W    = cb_idx_w(RES_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic                step,
  input  logic                comp,
  output logic [RES_BITS-1:0] code,
  output logic [RES_BITS-1:0] decided,
  output logic                last_bit
);

  localparam logic [IDX_W-1:0]    TOP_IDX  = IDX_W'(RES_BITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [RES_BITS-1:0] CODE_ONE = RES_BITS'(1);
  localparam logic [RES_BITS-1:0] MSB_ONLY = CODE_ONE << (RES_BITS - 1);

  logic [IDX_W-1:0]    bit_idx;
  logic [RES_BITS-1:0] advanced;

  assign last_bit = (bit_idx == '0);

  // Apply the comparator decision to the bit under test, then propose the
  // next lower bit as the following trial.
  always_comb begin
    decided = code;
    if (!comp) begin
      decided[bit_idx] = 1'b0;
    end
    advanced = decided;
    if (!last_bit) begin
      advanced[bit_idx - IDX_ONE] = 1'b1;
    end
  end

  // Trial code and bit index; clear has priority so an abort always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code    <= '0;
      bit_idx <= '0;
    end else if (clear) begin
      code    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      code    <= MSB_ONLY;
      bit_idx <= TOP_IDX;
    end else if (step) begin
      code    <= advanced;
      bit_idx <= last_bit ? '0 : (bit_idx - IDX_ONE);
    end
  end

endmodule

// File: rtl/crossbar_sar_readout.sv
// Column-sweeping SAR readout for an analog crossbar. For each column it
// switches the analog mux, waits for settling, runs a binary search against
// an external comparator and offers the resulting code on a valid/ready port.
//
// Result handshake: res_valid is high only in OUTPUT and, once high, holds
// res_data/res_col/res_last stable until a cycle with res_valid && res_ready;
// that edge is the transfer. res_ready is ignored whenever res_valid is low.
module crossbar_sar_readout
  import crossbar_pkg::*;
#(
  parameter int  N_COLS        = CB_N_COLS_DEF,
  parameter int  RES_BITS      = CB_RES_BITS_DEF,
  parameter int  SETTLE_CYCLES = CB_SETTLE_CYCLES_DEF,
  localparam int COL_W         = cb_idx_w(N_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                comp,
  output logic [COL_W-1:0]    col_sel,
  output logic [RES_BITS-1:0] dac_code,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RES_BITS-1:0] res_data,
  output logic [COL_W-1:0]    res_col,
  output logic                res_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          fsm_state
);

  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(N_COLS - 1);
  localparam logic [COL_W-1:0]    COL_ONE  = COL_W'(1);
  localparam logic [CB_CNT_W-1:0] SETTLE   = CB_CNT_W'(SETTLE_CYCLES);
  localparam logic [CB_CNT_W-1:0] CNT_ONE  = CB_CNT_W'(1);

  logic [1:0]          state;
  logic [CB_CNT_W-1:0] cnt;
  logic                slot_end;
  logic                kill;
  logic                sar_clear;
  logic                sar_load;
  logic                sar_step;
  logic                sar_last;
  logic [RES_BITS-1:0] sar_code;
  logic [RES_BITS-1:0] sar_decided;

  assign slot_end  = (cnt == CNT_ONE);
  assign kill      = abort && (state != ST_IDLE);
  assign fsm_state = state;
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_OUTPUT);
  assign dac_code  = (state == ST_CONVERT) ? sar_code : '0;

  // SAR control strobes: load on leaving SELECT, step at the end of each
  // trial; abort and IDLE keep the register empty.
  always_comb begin
    sar_clear = kill || (state == ST_IDLE);
    sar_load  = 1'b0;
    sar_step  = 1'b0;
    if (!kill) begin
      sar_load = (state == ST_SELECT)  && slot_end;
      sar_step = (state == ST_CONVERT) && slot_end;
    end
  end

  crossbar_sar_bit #(
    .RES_BITS (RES_BITS)
  ) u_sar (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sar_clear),
    .load     (sar_load),
    .step     (sar_step),
    .comp     (comp),
    .code     (sar_code),
    .decided  (sar_decided),
    .last_bit (sar_last)
  );

  // Sweep FSM: column select, settle/trial timing, result capture and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      col_sel  <= '0;
      res_data <= '0;
      res_col  <= '0;
      res_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        col_sel <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state   <= ST_SELECT;
              col_sel <= '0;
              cnt     <= SETTLE;
            end
          end
          ST_SELECT: begin
            if (slot_end) begin
              state <= ST_CONVERT;
              cnt   <= SETTLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_CONVERT: begin
            if (slot_end) begin
              if (sar_last) begin
                state    <= ST_OUTPUT;
                cnt      <= '0;
                res_data <= sar_decided;
                res_col  <= col_sel;
                res_last <= (col_sel == LAST_COL);
              end else begin
                cnt <= SETTLE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_OUTPUT: begin
            if (res_ready) begin
              if (res_last) begin
                state   <= ST_IDLE;
                col_sel <= '0;
                done    <= 1'b1;
              end else begin
                state   <= ST_SELECT;
                col_sel <= col_sel + COL_ONE;
                cnt     <= SETTLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crossbar_sar_readout.sv
// Directed bench for crossbar_sar_readout with a behavioural comparator
// (column level >= DAC code) and SETTLE_CYCLES=3.
module tb_crossbar_sar_readout;
  import crossbar_pkg::*;

  localparam int N_COLS = 8;
  localparam int RES_BITS = 8;
  localparam int SETTLE = 3;
  localparam int COL_LAT = SETTLE * (RES_BITS + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       comp;
  logic [2:0] col_sel;
  logic [7:0] dac_code;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [2:0] res_col;
  logic       res_last;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;

  // Analog column levels and the codes a correct sweep must report.
  logic [7:0] lvl [8] = '{8'h00, 8'h12, 8'h7F, 8'hA5, 8'h80, 8'h01, 8'hFE, 8'hFF};
  logic [7:0] exp_codes [8] = '{8'h00, 8'h12, 8'h7F, 8'hA5, 8'h80, 8'h01, 8'hFE, 8'hFF};
  logic [7:0] exp_trail [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_data[$];
  logic [2:0] got_col[$];
  logic       got_last[$];
  logic [7:0] trail[$];
  int         done_cnt;
  int         first_valid;

  assign comp = (lvl[col_sel] >= dac_code);

  // Clock and reset block
  always #5 clk = ~clk;

  crossbar_sar_readout #(
    .N_COLS        (N_COLS),
    .RES_BITS      (RES_BITS),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .comp      (comp),
    .col_sel   (col_sel),
    .dac_code  (dac_code),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_col   (res_col),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    exp_q.delete();
    got_data.delete();
    got_col.delete();
    got_last.delete();
    trail.delete();
    done_cnt = 0;
    first_valid = -1;
    for (int i = 0; i < N_COLS; i++) exp_q.push_back(exp_codes[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int col, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (fsm_state == st && int'(col_sel) == col) begin
        ok = 1'b1;
        break;
      end
      step_clk();
    end
  endtask

  // Run with res_ready=1 until the sweep ends, logging results, done pulses,
  // the DAC trials of one column, and optionally pulsing start mid-sweep.
  task automatic collect(input int max_cyc, input int trail_col, input int inject_col,
                         output bit timed_out);
    bit injected;
    injected = 1'b0;
    timed_out = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (res_valid && first_valid < 0) first_valid = i;
      if (res_valid && res_ready) begin
        got_data.push_back(res_data);
        got_col.push_back(res_col);
        got_last.push_back(res_last);
      end
      if (done) done_cnt++;
      if (fsm_state == ST_CONVERT && int'(col_sel) == trail_col &&
          (trail.size() == 0 || trail[$] != dac_code)) trail.push_back(dac_code);
      start = 1'b0;
      if (!injected && fsm_state == ST_CONVERT && int'(col_sel) == inject_col) begin
        start = 1'b1;
        injected = 1'b1;
      end
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      step_clk();
    end
    start = 1'b0;
  endtask

  // Scoreboard: compare logged results against the expected queue.
  task automatic check_sweep(input string name, input int first_col);
    logic [7:0] e;
    tests_run++;
    if (got_data.size() != N_COLS - first_col) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, got_data.size(), N_COLS - first_col);
    end
    for (int i = 0; i < first_col; i++) void'(exp_q.pop_front());
    for (int i = 0; i < got_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (got_data[i] !== e || got_col[i] !== 3'(i + first_col) || got_last[i] !== (i + first_col == 7)) begin
        tests_failed++;
        $display("FAIL %s_result[%0d]: got data=%h col=%0d last=%b, expected data=%h col=%0d last=%b",
                 name, i, got_data[i], got_col[i], got_last[i], e, i + first_col, (i + first_col == 7));
      end
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({busy, res_valid, done, res_last, dac_code, col_sel, res_data, res_col, fsm_state} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b valid=%b done=%b last=%b dac=%h col=%0d data=%h rcol=%0d st=%0d, expected all 0",
               busy, res_valid, done, res_last, dac_code, col_sel, res_data, res_col, fsm_state);
    end
    step_clk();
    rst_n = 1'b1;
    step_clk();
  endtask

  task automatic test_full_sweep();
    bit to;
    clear_log();
    pulse_start();
    tests_run++;
    if (fsm_state !== ST_SELECT || busy !== 1'b1 || col_sel !== 3'd0) begin
      tests_failed++;
      $display("FAIL sweep_select_entry: got st=%0d busy=%b col=%0d, expected st=1 busy=1 col=0", fsm_state, busy, col_sel);
    end
    collect(2000, 3, -1, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL sweep_timeout: sweep did not finish, expected finish within 2000 cycles");
    end
    check_sweep("sweep", 0);
    tests_run++;
    if (first_valid != COL_LAT) begin
      tests_failed++;
      $display("FAIL sweep_latency: got %0d cycles, expected %0d", first_valid, COL_LAT);
    end
    tests_run++;
    if (trail.size() != 8) begin
      tests_failed++;
      $display("FAIL trail_len: got %0d trials, expected 8", trail.size());
    end
    for (int i = 0; i < trail.size() && i < 8; i++) begin
      tests_run++;
      if (trail[i] !== exp_trail[i]) begin
        tests_failed++;
        $display("FAIL trail[%0d]: got %h, expected %h", i, trail[i], exp_trail[i]);
      end
    end
    step_clk();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_done_width: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit to;
    res_ready = 1'b1;
    pulse_start();
    wait_state(ST_CONVERT, 3, 1000, ok);
    res_ready = 1'b0;
    wait_state(ST_OUTPUT, 3, 200, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL bp_reach_col3: timed out, expected OUTPUT of col3");
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== 8'hA5 || res_col !== 3'd3 || res_last !== 1'b0 || dac_code !== 8'h00) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h col=%0d last=%b dac=%h, expected 1 a5 3 0 00",
                 i, res_valid, res_data, res_col, res_last, dac_code);
      end
      step_clk();
    end
    res_ready = 1'b1;
    step_clk();
    tests_run++;
    if (fsm_state !== ST_SELECT || col_sel !== 3'd4 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_resume: got st=%0d col=%0d valid=%b, expected st=1 col=4 valid=0", fsm_state, col_sel, res_valid);
    end
    clear_log();
    collect(2000, -1, -1, to);
    check_sweep("bp_tail", 4);
    step_clk();
  endtask

  task automatic test_abort();
    bit ok;
    bit to;
    bit saw_done;
    res_ready = 1'b1;
    pulse_start();
    wait_state(ST_CONVERT, 5, 1000, ok);
    step_clk();
    step_clk();
    step_clk();
    tests_run++;
    if (!ok || fsm_state !== ST_CONVERT || dac_code === 8'h00) begin
      tests_failed++;
      $display("FAIL abort_setup: got ok=%b st=%0d dac=%h, expected CONVERT of col5 with nonzero dac", ok, fsm_state, dac_code);
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    tests_run++;
    if (fsm_state !== ST_IDLE || busy !== 1'b0 || res_valid !== 1'b0 || dac_code !== 8'h00 || col_sel !== 3'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got st=%0d busy=%b valid=%b dac=%h col=%0d done=%b, expected 0 0 0 00 0 0",
               fsm_state, busy, res_valid, dac_code, col_sel, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) saw_done = 1'b1;
      step_clk();
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got done pulse, expected none");
    end
    clear_log();
    pulse_start();
    collect(2000, -1, -1, to);
    check_sweep("abort_restart", 0);
    step_clk();
  endtask

  task automatic test_abort_vs_accept();
    bit ok;
    res_ready = 1'b0;
    pulse_start();
    wait_state(ST_OUTPUT, 0, 200, ok);
    res_ready = 1'b1;
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    tests_run++;
    if (!ok || fsm_state !== ST_IDLE || col_sel !== 3'd0 || res_valid !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_accept: got ok=%b st=%0d col=%0d valid=%b done=%b, expected 1 0 0 0 0",
               ok, fsm_state, col_sel, res_valid, done);
    end
    start = 1'b1;
    abort = 1'b1;
    step_clk();
    start = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL abort_start_idle: got busy=%b st=%0d, expected 0 0", busy, fsm_state);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    clear_log();
    pulse_start();
    collect(2000, -1, 2, to);
    check_sweep("start_busy", 0);
    step_clk();
    step_clk();
    tests_run++;
    if (busy !== 1'b0 || fsm_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL start_busy_idle: got busy=%b st=%0d, expected 0 0", busy, fsm_state);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit to;
    res_ready = 1'b1;
    pulse_start();
    wait_state(ST_CONVERT, 4, 1000, ok);
    step_clk();
    step_clk();
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || {busy, res_valid, done, res_last, dac_code, col_sel, res_data, res_col, fsm_state} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got ok=%b busy=%b valid=%b done=%b last=%b dac=%h col=%0d data=%h rcol=%0d st=%0d, expected ok=1 and all 0",
               ok, busy, res_valid, done, res_last, dac_code, col_sel, res_data, res_col, fsm_state);
    end
    step_clk();
    step_clk();
    rst_n = 1'b1;
    step_clk();
    clear_log();
    pulse_start();
    tests_run++;
    if (col_sel !== 3'd0 || fsm_state !== ST_SELECT) begin
      tests_failed++;
      $display("FAIL reset_restart_col: got col=%0d st=%0d, expected 0 1", col_sel, fsm_state);
    end
    collect(2000, -1, -1, to);
    check_sweep("reset_restart", 0);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_abort();
    test_abort_vs_accept();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
